claw_mechanism: RTL and testbench
=================================

CLAW_MECHANISM -- requirements
Module: claw_mechanism

Interface
REQ-001 SHALL have parameter XMAX, default 7, highest X cell index.
REQ-002 SHALL have parameter YMAX, default 7, highest Y cell index.
REQ-003 SHALL have parameter ZDEPTH, default 6, Z steps from top to floor.
REQ-004 SHALL have parameter STEP_CYC, default 2, clock cycles per one-cell/one-step move.
REQ-005 SHALL have parameter DROP_CYC, default 3, cycles Drop is held low.
REQ-006 SHALL have parameter PRIZE_MAP, default 64'h0000_0018_1800_0000, bit (y*8+x) = prize present.
REQ-007 SHALL have ports: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-008 SHALL have ports: Claw_l, Claw_r, Claw_f, Claw_b input 1 each, level move commands.
REQ-009 SHALL have ports: Return, Down, Rise input 1, homing/lower/raise commands; Open, Tight, Loose, Release input 1, gripper commands.
REQ-010 SHALL have ports: Touch, Top, Origin output 1, one-cycle sensor pulses; Drop output 1, prize-chute sensor, active-low.
REQ-011 SHALL have ports: pos_x output 3, pos_y output 3, pos_z output 3, holding output 1, observable mechanism state.

Function
REQ-012 SHALL implement states IDLE, MOVE, LOWER, BOTTOM, RAISE, HOMING, DROPPING.
REQ-013 SHALL run a step prescaler counting 0..STEP_CYC-1 in MOVE/LOWER/RAISE/HOMING; a step occurs on wrap; prescaler clears on every state change.
REQ-014 SHALL, in IDLE/MOVE with pos_z==0, move X (Claw_r +1, Claw_l -1) and Y (Claw_b +1, Claw_f -1) once per step, saturating at 0 and XMAX/YMAX.
REQ-015 SHALL make no move on an axis when both opposing commands are high.
REQ-016 SHALL use command priority Return > Rise > Down > moves when sampled in IDLE/MOVE.
REQ-017 SHALL, in LOWER, increment pos_z per step; on reaching ZDEPTH, pulse Touch one cycle and enter BOTTOM.
REQ-018 SHALL, in BOTTOM, set holding on Tight (subject to REQ-029); Open clears holding; Rise enters RAISE.
REQ-019 SHALL, in RAISE, decrement pos_z per step; Loose high in any RAISE cycle clears holding; on pos_z==0, pulse Top one cycle, enter IDLE.
REQ-020 SHALL, in HOMING, decrement pos_x and pos_y together per step (each stops at 0); when both 0, pulse Origin one cycle, enter IDLE.
REQ-021 SHALL pulse Origin one cycle immediately (no step) when Return is accepted already at (0,0).
REQ-022 SHALL ignore Return and moves while pos_z!=0.
REQ-023 SHALL, in IDLE at (0,0,0) with holding=1, on Release or Open, clear holding, drive Drop low for exactly DROP_CYC cycles (DROPPING), then return to IDLE.
REQ-024 SHALL ignore Release/Open when holding=0 (Drop stays high).
REQ-025 SHALL ignore all commands during DROPPING.
REQ-026 SHALL register all outputs; Touch/Top/Origin never high more than one consecutive cycle.

Reset
REQ-027 SHALL on rst high, immediately: state IDLE, pos_x=pos_y=pos_z=0, holding=0, prescaler 0, Touch=Top=Origin=0, Drop=1.
REQ-028 SHALL abort any operation on mid-operation reset with no pulse emitted at reset release.

Configuration
REQ-029 SHALL with CLAW_PRIZE_MAP_EN defined set holding on Tight only if PRIZE_MAP bit (pos_y*8+pos_x) is 1; without it, Tight in BOTTOM always sets holding and PRIZE_MAP is unused.

Verification
REQ-030 SHALL cover: reset, Claw_r held 10 steps then Claw_b 3 steps -> pos_x=7 (saturated), pos_y=3.
REQ-031 SHALL cover: Down in IDLE -> pos_z reaches 6 after 6*STEP_CYC cycles, single Touch pulse; Rise -> pos_z 0, single Top pulse.
REQ-032 SHALL cover: at (3,3) with CLAW_PRIZE_MAP_EN, Tight in BOTTOM -> holding=1; at (0,0) -> holding=0; without macro both -> holding=1.
REQ-033 SHALL cover: holding=1, Loose pulsed during RAISE -> holding=0; Return then Release -> Origin pulse, Drop stays 1.
REQ-034 SHALL cover: holding=1 from (3,3), Return -> Origin after 3 steps; Release -> Drop low exactly 3 cycles, holding=0.
REQ-035 SHALL cover: rst asserted mid-LOWER at pos_z=3 -> all positions 0, Drop=1, no Touch after release.

Source files
------------

// File: rtl/claw_mechanism_if.sv
// rtl/claw_mechanism_if.sv - Command and sensor bundle between the claw machine panel and the claw mechanism
interface claw_mechanism_if;
    logic       Claw_l;
    logic       Claw_r;
    logic       Claw_f;
    logic       Claw_b;
    logic       Return;
    logic       Down;
    logic       Rise;
    logic       Open;
    logic       Tight;
    logic       Loose;
    logic       Release;
    logic       Touch;
    logic       Top;
    logic       Origin;
    logic       Drop;
    logic [2:0] pos_x;
    logic [2:0] pos_y;
    logic [2:0] pos_z;
    logic       holding;

    modport master (
        output Claw_l, Claw_r, Claw_f, Claw_b,
        output Return, Down, Rise,
        output Open, Tight, Loose, Release,
        input  Touch, Top, Origin, Drop,
        input  pos_x, pos_y, pos_z, holding
    );

    modport slave (
        input  Claw_l, Claw_r, Claw_f, Claw_b,
        input  Return, Down, Rise,
        input  Open, Tight, Loose, Release,
        output Touch, Top, Origin, Drop,
        output pos_x, pos_y, pos_z, holding
    );
endinterface

// File: rtl/claw_mechanism.sv
// rtl/claw_mechanism.sv - Claw machine mechanism model (XY gantry, Z hoist, gripper, prize chute); optional CLAW_PRIZE_MAP_EN
module claw_mechanism #(
    parameter int          XMAX      = 7,
    parameter int          YMAX      = 7,
    parameter int          ZDEPTH    = 6,
    parameter int          STEP_CYC  = 2,
    parameter int          DROP_CYC  = 3,
    parameter logic [63:0] PRIZE_MAP = 64'h0000_0018_1800_0000
) (
    input  logic            clk,
    input  logic            rst,
    claw_mechanism_if.slave bus
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_MOVE     = 3'd1;
    localparam logic [2:0] S_LOWER    = 3'd2;
    localparam logic [2:0] S_BOTTOM   = 3'd3;
    localparam logic [2:0] S_RAISE    = 3'd4;
    localparam logic [2:0] S_HOMING   = 3'd5;
    localparam logic [2:0] S_DROPPING = 3'd6;

    logic [2:0]  state;
    logic [2:0]  state_nx;
    logic [15:0] presc;
    logic [15:0] drop_cnt;
    logic [2:0]  pos_x;
    logic [2:0]  pos_y;
    logic [2:0]  pos_z;
    logic        holding;
    logic        touch;
    logic        top;
    logic        origin;
    logic        drop_n;
    logic        ret_q;

    logic step;
    logic counting;
    logic at_origin;
    logic at_top;
    logic ret_ok;
    logic down_ok;
    logic drop_req;
    logic x_inc;
    logic x_dec;
    logic y_inc;
    logic y_dec;
    logic any_move;
    logic tight_ok;

    assign step      = (presc == 16'(STEP_CYC - 1));
    assign counting  = (state == S_MOVE) || (state == S_LOWER) ||
                       (state == S_RAISE) || (state == S_HOMING);
    assign at_origin = (pos_x == 3'd0) && (pos_y == 3'd0);
    assign at_top    = (pos_z == 3'd0);
    assign ret_ok    = bus.Return && at_top;
    assign down_ok   = bus.Down && at_top;
    assign drop_req  = holding && at_origin && at_top && (bus.Release || bus.Open);

    // Opposing commands on one axis cancel; saturation is folded in so a
    // pinned axis does not keep the gantry in MOVE.
    assign x_inc    = bus.Claw_r && !bus.Claw_l && (pos_x != 3'(XMAX));
    assign x_dec    = bus.Claw_l && !bus.Claw_r && (pos_x != 3'd0);
    assign y_inc    = bus.Claw_b && !bus.Claw_f && (pos_y != 3'(YMAX));
    assign y_dec    = bus.Claw_f && !bus.Claw_b && (pos_y != 3'd0);
    assign any_move = x_inc || x_dec || y_inc || y_dec;

`ifdef CLAW_PRIZE_MAP_EN
    assign tight_ok = PRIZE_MAP[{pos_y, pos_x}];
`else
    logic unused_prize_map;
    assign tight_ok         = 1'b1;
    assign unused_prize_map = ^PRIZE_MAP;
`endif

    // Next-state selection; IDLE/MOVE arbitrate Return > Rise > Down > drop > moves.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_MOVE: begin
                if (ret_ok)
                    state_nx = at_origin ? S_IDLE : S_HOMING;
                else if (bus.Rise)
                    state_nx = S_IDLE;
                else if (down_ok)
                    state_nx = S_LOWER;
                else if ((state == S_IDLE) && drop_req)
                    state_nx = S_DROPPING;
                else if (any_move && at_top)
                    state_nx = S_MOVE;
                else
                    state_nx = S_IDLE;
            end
            S_LOWER: begin
                if (step && (pos_z == 3'(ZDEPTH - 1)))
                    state_nx = S_BOTTOM;
            end
            S_BOTTOM: begin
                if (bus.Rise)
                    state_nx = S_RAISE;
            end
            S_RAISE: begin
                if (step && (pos_z == 3'd1))
                    state_nx = S_IDLE;
            end
            S_HOMING: begin
                if (step && (pos_x <= 3'd1) && (pos_y <= 3'd1))
                    state_nx = S_IDLE;
            end
            S_DROPPING: begin
                if (drop_cnt == 16'(DROP_CYC - 1))
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State register and step prescaler; any state change restarts the prescaler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            presc <= 16'd0;
        end else begin
            state <= state_nx;
            if (state_nx != state)
                presc <= 16'd0;
            else if (counting)
                presc <= step ? 16'd0 : presc + 16'd1;
            else
                presc <= 16'd0;
        end
    end

    // Mechanism datapath: positions, gripper, chute and one-cycle sensor pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_x    <= 3'd0;
            pos_y    <= 3'd0;
            pos_z    <= 3'd0;
            holding  <= 1'b0;
            touch    <= 1'b0;
            top      <= 1'b0;
            origin   <= 1'b0;
            drop_n   <= 1'b1;
            drop_cnt <= 16'd0;
            ret_q    <= 1'b0;
        end else begin
            touch  <= 1'b0;
            top    <= 1'b0;
            origin <= 1'b0;
            ret_q  <= bus.Return;
            case (state)
                S_IDLE, S_MOVE: begin
                    if (ret_ok) begin
                        // Held Return at origin reports once, not every cycle.
                        if (at_origin && !ret_q)
                            origin <= 1'b1;
                    end else if (!bus.Rise && !down_ok) begin
                        if ((state == S_IDLE) && drop_req) begin
                            holding  <= 1'b0;
                            drop_n   <= 1'b0;
                            drop_cnt <= 16'd0;
                        end else if ((state == S_MOVE) && step && at_top) begin
                            if (x_inc)
                                pos_x <= pos_x + 3'd1;
                            else if (x_dec)
                                pos_x <= pos_x - 3'd1;
                            if (y_inc)
                                pos_y <= pos_y + 3'd1;
                            else if (y_dec)
                                pos_y <= pos_y - 3'd1;
                        end
                    end
                end
                S_LOWER: begin
                    if (step) begin
                        pos_z <= pos_z + 3'd1;
                        if (pos_z == 3'(ZDEPTH - 1))
                            touch <= 1'b1;
                    end
                end
                S_BOTTOM: begin
                    if (bus.Tight && tight_ok)
                        holding <= 1'b1;
                    if (bus.Open)
                        holding <= 1'b0;
                end
                S_RAISE: begin
                    if (bus.Loose)
                        holding <= 1'b0;
                    if (step) begin
                        pos_z <= pos_z - 3'd1;
                        if (pos_z == 3'd1)
                            top <= 1'b1;
                    end
                end
                S_HOMING: begin
                    if (step) begin
                        if (pos_x != 3'd0)
                            pos_x <= pos_x - 3'd1;
                        if (pos_y != 3'd0)
                            pos_y <= pos_y - 3'd1;
                        if ((pos_x <= 3'd1) && (pos_y <= 3'd1))
                            origin <= 1'b1;
                    end
                end
                S_DROPPING: begin
                    if (drop_cnt == 16'(DROP_CYC - 1))
                        drop_n <= 1'b1;
                    else
                        drop_cnt <= drop_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.pos_x   = pos_x;
    assign bus.pos_y   = pos_y;
    assign bus.pos_z   = pos_z;
    assign bus.holding = holding;
    assign bus.Touch   = touch;
    assign bus.Top     = top;
    assign bus.Origin  = origin;
    assign bus.Drop    = drop_n;

endmodule

// File: tb/tb_claw_mechanism.sv
// tb/tb_claw_mechanism.sv - Directed self-checking bench for claw_mechanism
module tb_claw_mechanism;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic exp_hold_33;
    logic exp_hold_00;
    logic touch_seen;
    logic z_moved;

    claw_mechanism_if bus();

    claw_mechanism dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_hold_33 = 1'b1;
`ifdef CLAW_PRIZE_MAP_EN
        exp_hold_00 = 1'b0;
`else
        exp_hold_00 = 1'b1;
`endif
        rst = 1'b1;
        bus.Claw_l = 1'b0; bus.Claw_r = 1'b0; bus.Claw_f = 1'b0; bus.Claw_b = 1'b0;
        bus.Return = 1'b0; bus.Down = 1'b0; bus.Rise = 1'b0;
        bus.Open = 1'b0; bus.Tight = 1'b0; bus.Loose = 1'b0; bus.Release = 1'b0;
        tick(2);
        check("rst_pos_x", 8'(bus.pos_x), 8'd0);
        check("rst_pos_y", 8'(bus.pos_y), 8'd0);
        check("rst_pos_z", 8'(bus.pos_z), 8'd0);
        check("rst_holding", 8'(bus.holding), 8'd0);
        check("rst_pulses", 8'({bus.Touch, bus.Top, bus.Origin}), 8'd0);
        check("rst_drop", 8'(bus.Drop), 8'd1);
        rst = 1'b0;
        tick(1);

        // X held far beyond the edge saturates at 7
        bus.Claw_r = 1'b1;
        tick(25);
        check("x_saturate", 8'(bus.pos_x), 8'd7);
        bus.Claw_r = 1'b0;
        // Y: entry cycle then one step every 2 cycles
        bus.Claw_b = 1'b1;
        tick(6);
        check("y_two_steps", 8'(bus.pos_y), 8'd2);
        tick(1);
        check("y_three_steps", 8'(bus.pos_y), 8'd3);
        bus.Claw_b = 1'b0;
        tick(3);
        check("y_stopped", 8'(bus.pos_y), 8'd3);
        // Opposing commands cancel
        bus.Claw_l = 1'b1; bus.Claw_r = 1'b1;
        tick(6);
        check("x_cancel", 8'(bus.pos_x), 8'd7);
        bus.Claw_l = 1'b0; bus.Claw_r = 1'b0;
        tick(1);

        // Lower: floor reached 12 cycles after acceptance, single Touch
        bus.Down = 1'b1;
        tick(1);
        bus.Down = 1'b0;
        tick(11);
        check("z_before_floor", 8'(bus.pos_z), 8'd5);
        check("touch_early", 8'(bus.Touch), 8'd0);
        tick(1);
        check("z_floor", 8'(bus.pos_z), 8'd6);
        check("touch_pulse", 8'(bus.Touch), 8'd1);
        tick(1);
        check("touch_single", 8'(bus.Touch), 8'd0);
        // Raise: back to 0, single Top
        bus.Rise = 1'b1;
        tick(1);
        bus.Rise = 1'b0;
        tick(11);
        check("z_before_top", 8'(bus.pos_z), 8'd1);
        tick(1);
        check("z_top", 8'(bus.pos_z), 8'd0);
        check("top_pulse", 8'(bus.Top), 8'd1);
        tick(1);
        check("top_single", 8'(bus.Top), 8'd0);

        // Move to (3,3)
        bus.Claw_l = 1'b1;
        tick(9);
        bus.Claw_l = 1'b0;
        tick(1);
        check("x_at_3", 8'(bus.pos_x), 8'd3);

        // Grab at (3,3), Loose during raise drops it
        bus.Down = 1'b1;
        tick(1);
        bus.Down = 1'b0;
        tick(12);
        bus.Tight = 1'b1;
        tick(1);
        bus.Tight = 1'b0;
        check("hold_33_a", 8'(bus.holding), 8'(exp_hold_33));
        bus.Rise = 1'b1;
        tick(1);
        bus.Rise = 1'b0;
        tick(2);
        bus.Loose = 1'b1;
        tick(1);
        bus.Loose = 1'b0;
        check("loose_clears", 8'(bus.holding), 8'd0);
        tick(9);
        check("z_top_loose", 8'(bus.pos_z), 8'd0);

        // Grab again at (3,3) and carry it home
        bus.Down = 1'b1;
        tick(1);
        bus.Down = 1'b0;
        tick(12);
        bus.Tight = 1'b1;
        tick(1);
        bus.Tight = 1'b0;
        check("hold_33_b", 8'(bus.holding), 8'(exp_hold_33));
        bus.Rise = 1'b1;
        tick(1);
        bus.Rise = 1'b0;
        tick(12);
        check("hold_after_raise", 8'(bus.holding), 8'(exp_hold_33));
        bus.Return = 1'b1;
        tick(1);
        bus.Return = 1'b0;
        tick(5);
        check("homing_mid_x", 8'(bus.pos_x), 8'd1);
        check("origin_early", 8'(bus.Origin), 8'd0);
        tick(1);
        check("homing_xy", 8'({bus.pos_y, bus.pos_x}), 8'd0);
        check("origin_pulse", 8'(bus.Origin), 8'd1);
        tick(1);
        check("origin_single", 8'(bus.Origin), 8'd0);
        // Release into the chute: Drop low exactly 3 cycles
        bus.Release = 1'b1;
        tick(1);
        bus.Release = 1'b0;
        check("drop_low_1", 8'(bus.Drop), 8'd0);
        check("drop_hold_clr", 8'(bus.holding), 8'd0);
        tick(2);
        check("drop_low_3", 8'(bus.Drop), 8'd0);
        tick(1);
        check("drop_released", 8'(bus.Drop), 8'd1);

        // Return at origin with empty claw, then Release does nothing
        bus.Return = 1'b1;
        tick(1);
        check("origin_immediate", 8'(bus.Origin), 8'd1);
        tick(1);
        check("origin_no_repeat", 8'(bus.Origin), 8'd0);
        bus.Return = 1'b0;
        bus.Release = 1'b1;
        tick(1);
        bus.Release = 1'b0;
        check("release_empty", 8'(bus.Drop), 8'd1);
        tick(1);
        check("release_empty_2", 8'(bus.Drop), 8'd1);

        // Grab at (0,0): prize map decides when enabled
        bus.Down = 1'b1;
        tick(1);
        bus.Down = 1'b0;
        tick(12);
        bus.Tight = 1'b1;
        tick(1);
        bus.Tight = 1'b0;
        check("hold_00", 8'(bus.holding), 8'(exp_hold_00));
        bus.Rise = 1'b1;
        tick(1);
        bus.Rise = 1'b0;
        tick(12);
        check("z_top_00", 8'(bus.pos_z), 8'd0);

        // Reset in the middle of a lowering
        bus.Claw_r = 1'b1;
        tick(5);
        bus.Claw_r = 1'b0;
        tick(1);
        check("x_at_2", 8'(bus.pos_x), 8'd2);
        bus.Down = 1'b1;
        tick(1);
        bus.Down = 1'b0;
        tick(6);
        check("z_mid_lower", 8'(bus.pos_z), 8'd3);
        rst = 1'b1;
        #1;
        check("arst_pos_x", 8'(bus.pos_x), 8'd0);
        check("arst_pos_z", 8'(bus.pos_z), 8'd0);
        check("arst_holding", 8'(bus.holding), 8'd0);
        check("arst_drop", 8'(bus.Drop), 8'd1);
        tick(1);
        rst = 1'b0;
        touch_seen = 1'b0;
        z_moved = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.Touch) touch_seen = 1'b1;
            if (bus.pos_z != 3'd0) z_moved = 1'b1;
        end
        check("no_touch_after_rst", 8'(touch_seen), 8'd0);
        check("z_stays_after_rst", 8'(z_moved), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
